led_sequencer: RTL
==================

// Module: led_sequencer
// PURPOSE
//  Parametrised successor to the 4-LED blinker. Drives NUM_LEDS outputs with
//  one of four patterns at a programmable step rate (delay from the HPS
//  delay_ctrl). Inputs are one-shot pulses: pause toggle, restart and single-step.
//  Sits between the key oneshot and the LED pins in the top level.
// PARAMETERS
//  NUM_LEDS       4   number of LED outputs; must be >= 2
//  DELAY_WIDTH    4   width of delay input
//  PRESCALE_WIDTH 20  base tick period = 2**PRESCALE_WIDTH clk cycles
// PORTS
//  clk      in   1            system clock (CLOCK_50)
//  reset_n  in   1            asynchronous reset, active-low
//  delay    in   DELAY_WIDTH  step interval = (delay+1) base ticks
//  mode     in   2            0 rotate-left, 1 bounce, 2 binary count, 3 blink
//  pause    in   1            one-cycle pulse: toggle running/paused
//  restart  in   1            one-cycle pulse: reload pattern, clear counters, run
//  step     in   1            one-cycle pulse: advance once (only while paused)
//  led      out  NUM_LEDS     registered pattern output
//  running  out  1            1 = sequencing, 0 = paused
// BEHAVIOUR
//  Reset: led=1 (bit0 set), running=1, prescaler=0, tick_cnt=0, mode_q=0, dir=left.
//  Prescaler: counts 0..2**PRESCALE_WIDTH-1 while running, then wraps.
//   base_tick=1 for the one cycle it equals max. Prescaler holds while paused.
//  tick_cnt (DELAY_WIDTH bits): on base_tick, if tick_cnt >= delay, assert advance
//   and clear tick_cnt; otherwise increment it. ">=" makes a delay decrease below
//   tick_cnt take effect on the next base_tick. delay=0 advances every base_tick.
//  Advance: led updates on the clk edge where advance is high. Zero extra latency.
//  Step-to-LED is one cycle (registered).
//  Patterns (next value on advance):
//   0 rotate: led <= {led[N-2:0], led[N-1]}.
//   1 bounce: one-hot shifts toward dir. On reaching bit N-1, dir flips to right.
//     On reaching bit 0, dir flips to left. Ends are shown once (no repeat).
//   2 count: led <= led + 1, mod 2**NUM_LEDS (wraps all-ones -> 0).
//   3 blink: led <= ~led. Start value 0 -> all on/all off.
//  Mode change: mode_q registers mode every cycle. If mode != mode_q, on that
//   edge led loads the start value (1 for modes 0/1, 0 for 2/3), dir=left and
//   tick_cnt=0. Any advance in that cycle is discarded. The prescaler is untouched.
//  Restart: led = start value of current mode, dir=left, prescaler=0,
//   tick_cnt=0, running=1. Applies on the next edge.
//  Pause: toggles running. Step while paused forces one advance on the next edge.
//   Step while running is ignored.
//  Priority in the same cycle: restart > mode change > pause/step.
//   restart+pause gives running=1 (pause is ignored).
//   pause+step while paused: step advances and running becomes 1.
//   pause+step while running: pause only.
//  Bounce: the pattern must stay one-hot. No illegal state is reachable from
//   reset/restart/mode load.
//  reset_n low mid-operation returns every register to its reset value immediately
//   (asynchronously). Release is synchronous to clk.
// TESTING (bench with PRESCALE_WIDTH=2, NUM_LEDS=4, so base_tick every 4 cycles)
//  Reset, mode=0, delay=0 -> led 0001,0010,0100,1000,0001 at 4-cycle spacing.
//  mode=1, delay=1 -> 0001,0010,0100,1000,0100,0010,0001,0010, one step
//   per 8 cycles.
//  mode=2, delay=0 -> counts 0..15 then wraps to 0. mode=3 -> alternates 0000/1111.
//  pause pulse -> led frozen for 100 cycles, running=0. Three step pulses
//   -> exactly three advances. pause -> resumes.
//  Set delay=15 with tick_cnt=10, then drop delay to 2 -> advance on the next
//   base_tick. Switch mode 2->0 mid-count -> led=0001 on the next edge.
//  Same-cycle restart+pause while paused -> running=1, led=start value.
//  Assert reset_n mid-bounce -> led=0001, running=1 immediately (no clk edge).

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate, bounce, binary count and blink at a
// programmable step rate, with pause, restart and single-step control.
module led_sequencer #(
    parameter int NUM_LEDS       = 4,
    parameter int DELAY_WIDTH    = 4,
    parameter int PRESCALE_WIDTH = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [1:0]             mode,
    input  logic                   pause,
    input  logic                   restart,
    input  logic                   step,
    output logic [NUM_LEDS-1:0]    led,
    output logic                   running
);

    localparam int N  = NUM_LEDS;
    localparam int PW = PRESCALE_WIDTH;
    localparam int DW = DELAY_WIDTH;

    localparam logic [N-1:0]  LED_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PS_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] TC_ONE  = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic {
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    logic [PW-1:0] prescaler;
    logic [DW-1:0] tick_cnt;
    logic [1:0]    mode_q;
    dir_t          dir;

    logic          base_tick;
    logic          advance;
    logic          mode_chg;
    logic          do_adv;
    logic [N-1:0]  start_val;
    logic [N-1:0]  next_led;
    dir_t          next_dir;

    assign base_tick = running && (prescaler == '1);
    assign advance   = base_tick && (tick_cnt >= delay);
    assign mode_chg  = (mode != mode_q);
    assign start_val = mode[1] ? '0 : LED_ONE;
    // A step pulse only counts while paused; while running the timer rules.
    assign do_adv    = running ? advance : step;

    always_comb begin
        next_led = led;
        next_dir = dir;
        unique case (mode_q)
            2'd0: next_led = {led[N-2:0], led[N-1]};
            2'd1: begin
                if (dir == DIR_LEFT) begin
                    next_led = led << 1;
                    if (next_led[N-1]) next_dir = DIR_RIGHT;
                end else begin
                    next_led = led >> 1;
                    if (next_led[0]) next_dir = DIR_LEFT;
                end
            end
            2'd2: next_led = led + LED_ONE;
            2'd3: next_led = ~led;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led       <= LED_ONE;
            running   <= 1'b1;
            prescaler <= '0;
            tick_cnt  <= '0;
            mode_q    <= 2'd0;
            dir       <= DIR_LEFT;
        end else begin
            mode_q <= mode;
            if (restart) begin
                led       <= start_val;
                dir       <= DIR_LEFT;
                prescaler <= '0;
                tick_cnt  <= '0;
                running   <= 1'b1;
            end else begin
                if (running) prescaler <= prescaler + PS_ONE;
                if (mode_chg) begin
                    // New mode restarts its pattern; this cycle's advance is dropped.
                    led      <= start_val;
                    dir      <= DIR_LEFT;
                    tick_cnt <= '0;
                end else begin
                    if (base_tick) tick_cnt <= advance ? '0 : tick_cnt + TC_ONE;
                    if (do_adv) begin
                        led <= next_led;
                        dir <= next_dir;
                    end
                    running <= running ^ pause;
                end
            end
        end
    end

endmodule
